cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have no parameters; widths come from lc3b_types (lc3b_word = 16 bits, lc3b_cacheline = 128 bits).
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low; state changes from release are clk-synchronous.
REQ-004 i_pmem_read  in  1  instruction-cache line-fill request; held until i_pmem_resp.
REQ-005 i_pmem_address  in  16  instruction-cache line address.
REQ-006 i_pmem_resp  out  1  one-cycle completion pulse to the instruction cache.
REQ-007 i_pmem_rdata  out  128  line data to the instruction cache.
REQ-008 d_pmem_read, d_pmem_write  in  1 each  data-cache fill and writeback requests; held until d_pmem_resp.
REQ-009 d_pmem_address  in  16  data-cache line address.
REQ-010 d_pmem_wdata  in  128  data-cache writeback line.
REQ-011 d_pmem_resp  out  1  one-cycle completion pulse to the data cache.
REQ-012 d_pmem_rdata  out  128  line data to the data cache.
REQ-013 pmem_read, pmem_write  out  1 each  requests to physical memory.
REQ-014 pmem_address  out  16  physical memory address.
REQ-015 pmem_wdata  out  128  physical memory write line.
REQ-016 pmem_resp  in  1  physical memory completion pulse.
REQ-017 pmem_rdata  in  128  physical memory read line.

Function
REQ-018 The FSM SHALL have 3 states: IDLE, SERVE_I, SERVE_D; 1-bit register last_grant (I or D).
REQ-019 Requests: i_req = i_pmem_read; d_req = d_pmem_read | d_pmem_write.
REQ-020 IDLE transitions: i_req only -> SERVE_I; d_req only -> SERVE_D; both -> the side not equal to last_grant; neither -> IDLE.
REQ-021 On entering SERVE_x, last_grant SHALL be set to x in the same edge.
REQ-022 SERVE_x SHALL remain until pmem_resp = 1, then go to IDLE on the next edge; there is no state skipping and no direct SERVE_I <-> SERVE_D transition.
REQ-023 Granted-request latency SHALL be exactly 1 cycle: a request seen in IDLE on edge N drives pmem_read/pmem_write from cycle N onward.
REQ-024 In IDLE, pmem_read, pmem_write, i_pmem_resp and d_pmem_resp SHALL be 0, and pmem_address and pmem_wdata SHALL be 0.
REQ-025 In SERVE_I: pmem_read = i_pmem_read, pmem_write = 0, pmem_address = i_pmem_address, pmem_wdata = 0.
REQ-026 In SERVE_D, pmem_write = d_pmem_write and pmem_address = d_pmem_address.
REQ-027 In SERVE_D, pmem_read = d_pmem_read & ~d_pmem_write (write wins if both asserted), and pmem_wdata = d_pmem_wdata.
REQ-028 i_pmem_resp = pmem_resp in SERVE_I only; d_pmem_resp = pmem_resp in SERVE_D only; the non-granted side SHALL never see a resp.
REQ-029 i_pmem_rdata and d_pmem_rdata SHALL both equal pmem_rdata at all times; validity is qualified by the respective resp.
REQ-030 A requester dropping its request before pmem_resp SHALL NOT change state; the FSM waits for pmem_resp and forwards it gated as in REQ-028.
REQ-031 The forced IDLE cycle between transactions guarantees one dead cycle after every resp; back-to-back same-side requests SHALL be re-arbitrated against the other side.
REQ-032 pmem_resp arriving in IDLE SHALL be ignored.

Reset
REQ-033 While rst_n = 0: state = IDLE and last_grant = D (the first tie goes to I), and all outputs SHALL be as in REQ-024.
REQ-034 Reset asserted mid-transaction SHALL abort immediately with no resp to either side; a pending request SHALL be re-arbitrated after release.

Verification
REQ-035 I-only: i_pmem_read = 1, addr 0x1230 -> next cycle pmem_read = 1, pmem_address = 0x1230; pmem_resp with rdata X -> i_pmem_resp = 1, i_pmem_rdata = X, d_pmem_resp = 0, then IDLE.
REQ-036 Tie after reset: i_pmem_read and d_pmem_write asserted together -> SERVE_I first; after its resp and IDLE cycle, SERVE_D with pmem_write = 1, pmem_wdata = d_pmem_wdata.
REQ-037 Fairness: both requests held continuously for 4 transactions -> grants SHALL alternate I, D, I, D.
REQ-038 D writeback then fill: d_pmem_write to 0x4000, resp, then d_pmem_read to 0x4010 -> two separate SERVE_D transactions, each with correct read/write strobe and address.
REQ-039 Reset mid-SERVE_D: rst_n low while pmem_write = 1 -> pmem_write drops asynchronously and d_pmem_resp = 0; after release with d_req still high -> SERVE_D re-entered one cycle later.
REQ-040 Stray pmem_resp in IDLE -> no resp on either side and no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one physical-memory port between the I- and D-caches
//               with round-robin tie-breaking and a forced idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter (
    input  logic         clk,
    input  logic         rst_n,

    input  logic         i_pmem_read,
    input  logic [15:0]  i_pmem_address,
    output logic         i_pmem_resp,
    output logic [127:0] i_pmem_rdata,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [15:0]  d_pmem_address,
    input  logic [127:0] d_pmem_wdata,
    output logic         d_pmem_resp,
    output logic [127:0] d_pmem_rdata,

    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [127:0] pmem_rdata
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SERVE_I = 2'd1;
    localparam logic [1:0] c_SERVE_D = 2'd2;

    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_last_grant;
    logic       w_i_req;
    logic       w_d_req;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

    // Ties go to whichever side was not served last.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_i_req && w_d_req)
                    w_next_state = (r_last_grant == c_GRANT_I) ? c_SERVE_D : c_SERVE_I;
                else if (w_i_req)
                    w_next_state = c_SERVE_I;
                else if (w_d_req)
                    w_next_state = c_SERVE_D;
                else
                    w_next_state = c_IDLE;
            end
            c_SERVE_I, c_SERVE_D: begin
                if (pmem_resp)
                    w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_last_grant <= c_GRANT_D;
        end else begin
            r_state <= w_next_state;
            if (r_state == c_IDLE && w_next_state == c_SERVE_I)
                r_last_grant <= c_GRANT_I;
            else if (r_state == c_IDLE && w_next_state == c_SERVE_D)
                r_last_grant <= c_GRANT_D;
        end
    end

    // Outputs decode straight from state so an async reset silences the bus at once.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0000;
        pmem_wdata   = 128'h0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            c_SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            c_SERVE_D: begin
                pmem_read    = d_pmem_read & ~d_pmem_write;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Scoreboard bench for cache_arbiter grant order and bus routing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [127:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [127:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    cache_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_d;
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared;
    int   n_mismatched;

    localparam logic [127:0] c_D_WDATA = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Bounded wait for the next negedge at which a grant drives the bus.
    task automatic wait_grant(output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            #1;
            if (pmem_read || pmem_write) begin
                got = 1'b1;
                cyc = k;
                break;
            end
        end
    endtask

    // Serves n queued grants; drops each side's request after its resp when drop is set.
    task automatic test_sequence(input string name, input int n, input bit drop);
        exp_t         e;
        bit           got;
        int           cyc;
        logic [127:0] rd;
        for (int t = 0; t < n; t++) begin
            wait_grant(got, cyc);
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("FAIL %s_queue_empty txn=%0d", name, t);
                return;
            end
            e = exp_q.pop_front();
            n_compared++;
            if (!got || cyc !== 1) begin
                n_mismatched++;
                $display("FAIL %s_latency txn=%0d got=%0d cycles=%0d expected 1", name, t, got, cyc);
            end
            n_compared++;
            if ({pmem_read, pmem_write, pmem_address, pmem_wdata} !== {~e.wr, e.wr, e.addr, e.wdata}) begin
                n_mismatched++;
                $display("FAIL %s_bus txn=%0d rd=%b wr=%b addr=%h wdata=%h expected rd=%b wr=%b addr=%h wdata=%h",
                         name, t, pmem_read, pmem_write, pmem_address, pmem_wdata,
                         ~e.wr, e.wr, e.addr, e.wdata);
            end
            rd = rand_line();
            pmem_rdata = rd;
            pmem_resp  = 1'b1;
            #1;
            n_compared++;
            if ({i_pmem_resp, d_pmem_resp, i_pmem_rdata, d_pmem_rdata} !== {~e.is_d, e.is_d, rd, rd}) begin
                n_mismatched++;
                $display("FAIL %s_resp txn=%0d i_resp=%b d_resp=%b i_rdata=%h d_rdata=%h expected %b %b %h",
                         name, t, i_pmem_resp, d_pmem_resp, i_pmem_rdata, d_pmem_rdata, ~e.is_d, e.is_d, rd);
            end
            @(negedge clk);
            pmem_resp = 1'b0;
            if (drop) begin
                if (e.is_d) begin
                    d_pmem_read  = 1'b0;
                    d_pmem_write = 1'b0;
                end else begin
                    i_pmem_read = 1'b0;
                end
            end
            #1;
            n_compared++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
                n_mismatched++;
                $display("FAIL %s_dead_cycle txn=%0d rd=%b wr=%b i_resp=%b d_resp=%b expected all 0",
                         name, t, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        i_pmem_read  = 1'b1;
        d_pmem_write = 1'b1;
        pmem_resp    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_compared++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
            n_mismatched++;
            $display("FAIL reset_strobes rd=%b wr=%b i_resp=%b d_resp=%b expected all 0",
                     pmem_read, pmem_write, i_pmem_resp, d_pmem_resp);
        end
        n_compared++;
        if ({pmem_address, pmem_wdata} !== 144'h0) begin
            n_mismatched++;
            $display("FAIL reset_bus addr=%h wdata=%h expected 0", pmem_address, pmem_wdata);
        end
        i_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
        pmem_resp    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_i_only();
        @(negedge clk);
        i_pmem_address = 16'h1230;
        i_pmem_read    = 1'b1;
        exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h1230, wdata: 128'h0});
        #1;
        n_compared++;
        if (pmem_read !== 1'b0) begin
            n_mismatched++;
            $display("FAIL i_only_pre_grant pmem_read=%b expected 0", pmem_read);
        end
        test_sequence("i_only", 1, 1'b1);
    endtask

    task automatic test_tie_after_reset();
        apply_reset();
        i_pmem_address = 16'h0A00;
        d_pmem_address = 16'h0B00;
        d_pmem_wdata   = c_D_WDATA;
        i_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0A00, wdata: 128'h0});
        exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h0B00, wdata: c_D_WDATA});
        test_sequence("tie", 2, 1'b1);
    endtask

    task automatic test_fairness();
        @(negedge clk);
        i_pmem_address = 16'h0C10;
        d_pmem_address = 16'h0D20;
        d_pmem_wdata   = c_D_WDATA;
        i_pmem_read    = 1'b1;
        d_pmem_read    = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h0C10, wdata: 128'h0});
            exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 16'h0D20, wdata: c_D_WDATA});
        end
        test_sequence("fairness", 4, 1'b0);
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
    endtask

    task automatic test_writeback_fill();
        @(negedge clk);
        d_pmem_address = 16'h4000;
        d_pmem_wdata   = c_D_WDATA;
        d_pmem_write   = 1'b1;
        d_pmem_read    = 1'b1;
        exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h4000, wdata: c_D_WDATA});
        test_sequence("writeback", 1, 1'b1);
        d_pmem_address = 16'h4010;
        d_pmem_wdata   = 128'h5;
        d_pmem_read    = 1'b1;
        exp_q.push_back('{is_d: 1'b1, wr: 1'b0, addr: 16'h4010, wdata: 128'h5});
        test_sequence("fill", 1, 1'b1);
    endtask

    task automatic test_drop_request();
        @(negedge clk);
        i_pmem_address = 16'h2220;
        i_pmem_read    = 1'b1;
        @(negedge clk);
        i_pmem_read    = 1'b0;
        d_pmem_address = 16'h5550;
        d_pmem_read    = 1'b1;
        @(negedge clk);
        #1;
        n_compared++;
        if ({pmem_read, pmem_write, pmem_address, d_pmem_resp} !== {1'b0, 1'b0, 16'h2220, 1'b0}) begin
            n_mismatched++;
            $display("FAIL drop_hold rd=%b wr=%b addr=%h d_resp=%b expected 0 0 2220 0",
                     pmem_read, pmem_write, pmem_address, d_pmem_resp);
        end
        pmem_rdata = 128'h1;
        pmem_resp  = 1'b1;
        #1;
        n_compared++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b10) begin
            n_mismatched++;
            $display("FAIL drop_resp i_resp=%b d_resp=%b expected 1 0", i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        d_pmem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stray_resp();
        @(negedge clk);
        pmem_resp = 1'b1;
        #1;
        n_compared++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL stray_resp i_resp=%b d_resp=%b expected 0 0", i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        n_compared++;
        if ({pmem_read, pmem_write, pmem_address} !== 18'h0) begin
            n_mismatched++;
            $display("FAIL stray_state rd=%b wr=%b addr=%h expected idle", pmem_read, pmem_write, pmem_address);
        end
        i_pmem_address = 16'h7770;
        i_pmem_read    = 1'b1;
        exp_q.push_back('{is_d: 1'b0, wr: 1'b0, addr: 16'h7770, wdata: 128'h0});
        test_sequence("after_stray", 1, 1'b1);
    endtask

    task automatic test_reset_mid_serve();
        @(negedge clk);
        d_pmem_address = 16'h6000;
        d_pmem_wdata   = c_D_WDATA;
        d_pmem_write   = 1'b1;
        @(negedge clk);
        #1;
        n_compared++;
        if (pmem_write !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midreset_pre wr=%b expected 1", pmem_write);
        end
        #2;
        rst_n     = 1'b0;
        pmem_resp = 1'b1;
        #1;
        n_compared++;
        if ({pmem_write, pmem_read, pmem_address, i_pmem_resp, d_pmem_resp} !== 20'h0) begin
            n_mismatched++;
            $display("FAIL midreset_abort wr=%b rd=%b addr=%h i_resp=%b d_resp=%b expected all 0",
                     pmem_write, pmem_read, pmem_address, i_pmem_resp, d_pmem_resp);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        pmem_resp = 1'b0;
        exp_q.push_back('{is_d: 1'b1, wr: 1'b1, addr: 16'h6000, wdata: c_D_WDATA});
        test_sequence("midreset_rearb", 1, 1'b1);
    endtask

    initial begin
        n_compared     = 0;
        n_mismatched   = 0;
        rst_n          = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = 16'h0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = 16'h0;
        d_pmem_wdata   = 128'h0;
        pmem_resp      = 1'b0;
        pmem_rdata     = 128'h0;

        test_reset();
        test_i_only();
        test_tie_after_reset();
        test_fairness();
        test_writeback_fill();
        test_drop_request();
        test_stray_resp();
        test_reset_mid_serve();

        n_compared++;
        if (exp_q.size() !== 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_leftover remaining=%0d expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
